// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write port, packed multi-port read addresses/data and status.
// master drives requests; slave is the register file.
interface reg_file_mp_if #(
  parameter int unsigned address_width = 3,
  parameter int unsigned data_width    = 16,
  parameter int unsigned num_read      = 2
);
  localparam int unsigned LANES = data_width / 8;

  logic                              w_en;
  logic [address_width-1:0]          write_address;
  logic [data_width-1:0]             write_data;
  logic [LANES-1:0]                  byte_en;
  logic [num_read*address_width-1:0] read_address;
  logic [num_read*data_width-1:0]    read_data;
  logic                              busy;
  logic                              wr_drop;

  modport master (
    output w_en, write_address, write_data, byte_en, read_address,
    input  read_data, busy, wr_drop
  );

  modport slave (
    input  w_en, write_address, write_data, byte_en, read_address,
    output read_data, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-lane writes, optional write-to-read bypass,
// 0/1-cycle read latency and a post-reset clear sweep that zeroes every entry.
module reg_file_mp #(
  parameter int unsigned address_width = 3,
  parameter int unsigned data_width    = 16,
  parameter int unsigned num_read      = 2,
  parameter int unsigned read_latency  = 1,
  parameter int unsigned bypass        = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** address_width;
  localparam int unsigned LANES = data_width / 8;

  if ((data_width % 8) != 0 || num_read < 1 || num_read > 4 || read_latency > 1) begin : g_bad_cfg
    $fatal(1, "reg_file_mp: unsupported data_width/num_read/read_latency");
  end

  typedef enum logic {INIT, READY} state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     drop_q, drop_d;

  logic [data_width-1:0]    mem [DEPTH];

  logic                          fwd_en;
  logic [address_width-1:0]      rd_addr;
  logic [data_width-1:0]         rd_word;
  logic [num_read*data_width-1:0] rd_flat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    drop_d  = 1'b0;
    unique case (state_q)
      INIT: begin
        cnt_d  = cnt_q + 1'b1;
        drop_d = bus.w_en;
        if (cnt_q == '1) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  // Storage has no reset; the sweep provides the clear, and a reset edge leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem[cnt_q] <= '0;
      end else if (bus.w_en) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (bus.byte_en[l]) mem[bus.write_address][8*l +: 8] <= bus.write_data[8*l +: 8];
        end
      end
    end
  end

  assign fwd_en = bus.w_en && (state_q == READY) && (bypass != 0);

  // Per-port view: stored word, lane-merged with a same-cycle write, forced to zero while sweeping.
  always_comb begin
    rd_flat = '0;
    rd_addr = '0;
    rd_word = '0;
    for (int unsigned p = 0; p < num_read; p++) begin
      rd_addr = bus.read_address[p*address_width +: address_width];
      rd_word = mem[rd_addr];
      if (fwd_en && (rd_addr == bus.write_address)) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (bus.byte_en[l]) rd_word[8*l +: 8] = bus.write_data[8*l +: 8];
        end
      end
      if (state_q == INIT) rd_word = '0;
      rd_flat[p*data_width +: data_width] = rd_word;
    end
  end

  if (read_latency == 0) begin : g_comb_read
    assign bus.read_data = rd_flat;
  end else begin : g_reg_read
    logic [num_read*data_width-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (reset) rd_q <= '0;
      else       rd_q <= rd_flat;
    end
    assign bus.read_data = rd_q;
  end

  assign bus.busy    = busy_q;
  assign bus.wr_drop = drop_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: three reg_file_mp configurations share one stimulus stream and are
// compared against an array-based reference of the documented behaviour.
module tb_reg_file_mp;
  logic        clk;
  logic        reset;
  logic        w_en;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic [1:0]  be;
  logic [2:0]  ra [4];

  int checks = 0;
  int errors = 0;

  // a: 2 ports, registered, bypass; b: 4 ports, registered, no bypass; c: 4 ports, combinational, bypass
  reg_file_mp_if #(.address_width(3), .data_width(16), .num_read(2)) if_a ();
  reg_file_mp_if #(.address_width(3), .data_width(16), .num_read(4)) if_b ();
  reg_file_mp_if #(.address_width(3), .data_width(16), .num_read(4)) if_c ();

  assign if_a.w_en = w_en;  assign if_a.write_address = wa;  assign if_a.write_data = wd;  assign if_a.byte_en = be;
  assign if_b.w_en = w_en;  assign if_b.write_address = wa;  assign if_b.write_data = wd;  assign if_b.byte_en = be;
  assign if_c.w_en = w_en;  assign if_c.write_address = wa;  assign if_c.write_data = wd;  assign if_c.byte_en = be;
  assign if_a.read_address = {ra[1], ra[0]};
  assign if_b.read_address = {ra[3], ra[2], ra[1], ra[0]};
  assign if_c.read_address = {ra[3], ra[2], ra[1], ra[0]};

  reg_file_mp #(.address_width(3), .data_width(16), .num_read(2), .read_latency(1), .bypass(1))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  reg_file_mp #(.address_width(3), .data_width(16), .num_read(4), .read_latency(1), .bypass(0))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  reg_file_mp #(.address_width(3), .data_width(16), .num_read(4), .read_latency(0), .bypass(1))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: contents array plus the number of entries the sweep still has to clear.
  logic [15:0] m [8];
  int          sweep_left = 8;
  bit          armed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a, input bit byp);
    logic [15:0] v;
    if (sweep_left > 0) return 16'h0000;
    v = m[a];
    if (byp && w_en && a == wa) begin
      for (int l = 0; l < 2; l++) if (be[l]) v[8*l +: 8] = wd[8*l +: 8];
    end
    return v;
  endfunction

  task automatic comb_check();
    for (int p = 0; p < 4; p++) check_val("c_rd", {16'h0, if_c.read_data[p*16 +: 16]}, {16'h0, model_read(ra[p], 1'b1)});
  endtask

  // One clock: combinational checks before the edge, model update at the edge, registered checks after.
  task automatic cycle();
    logic [15:0] ea [2];
    logic [15:0] eb [4];
    bit          exp_drop;
    #1;
    if (armed) comb_check();
    for (int p = 0; p < 2; p++) ea[p] = model_read(ra[p], 1'b1);
    for (int p = 0; p < 4; p++) eb[p] = model_read(ra[p], 1'b0);
    @(posedge clk);
    exp_drop = 1'b0;
    if (reset) begin
      sweep_left = 8;
      armed = 1;
      for (int p = 0; p < 2; p++) ea[p] = 16'h0;
      for (int p = 0; p < 4; p++) eb[p] = 16'h0;
    end else if (sweep_left > 0) begin
      m[8 - sweep_left] = 16'h0;
      sweep_left--;
      exp_drop = w_en;
    end else if (w_en) begin
      for (int l = 0; l < 2; l++) if (be[l]) m[wa][8*l +: 8] = wd[8*l +: 8];
    end
    #1;
    if (armed) begin
      check_val("busy_a", {31'h0, if_a.busy}, {31'h0, sweep_left > 0});
      check_val("busy_b", {31'h0, if_b.busy}, {31'h0, sweep_left > 0});
      check_val("busy_c", {31'h0, if_c.busy}, {31'h0, sweep_left > 0});
      check_val("drop_a", {31'h0, if_a.wr_drop}, {31'h0, exp_drop});
      check_val("drop_b", {31'h0, if_b.wr_drop}, {31'h0, exp_drop});
      check_val("drop_c", {31'h0, if_c.wr_drop}, {31'h0, exp_drop});
      for (int p = 0; p < 2; p++) check_val("a_rd", {16'h0, if_a.read_data[p*16 +: 16]}, {16'h0, ea[p]});
      for (int p = 0; p < 4; p++) check_val("b_rd", {16'h0, if_b.read_data[p*16 +: 16]}, {16'h0, eb[p]});
    end
    @(negedge clk);
  endtask

  task automatic set_ra(input logic [2:0] a);
    for (int p = 0; p < 4; p++) ra[p] = a;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    w_en = 1'b1; wa = a; wd = d; be = b;
    cycle();
    w_en = 1'b0;
  endtask

  int bc;

  initial begin
    for (int i = 0; i < 8; i++) m[i] = 16'h0;
    reset = 1'b1; w_en = 1'b1; wa = 3'd5; wd = 16'hFFFF; be = 2'b11;
    set_ra(3'd0);

    // Sweep with writes held on: all rejected, busy for 8 cycles, then everything reads zero.
    cycle(); cycle();
    reset = 1'b0;
    bc = int'(if_a.busy);
    for (int i = 0; i < 12; i++) begin
      w_en = (i < 8);
      cycle();
      bc += int'(if_a.busy);
    end
    check_val("busy_len", bc, 8);
    for (int a = 0; a < 8; a++) begin
      set_ra(3'(a));
      cycle();
      check_val("swept", {16'h0, if_a.read_data[15:0]}, 32'h0);
    end

    // Byte-lane write.
    wr(3'd3, 16'hA55A, 2'b11);
    wr(3'd3, 16'h1234, 2'b01);
    ra[0] = 3'd3; ra[1] = 3'd2;
    cycle();
    check_val("lane_p0", {16'h0, if_a.read_data[15:0]}, 32'hA534);
    check_val("lane_p1", {16'h0, if_a.read_data[31:16]}, 32'h0000);

    // Same-cycle write/read of one entry, with and without forwarding.
    wr(3'd6, 16'h00FF, 2'b11);
    set_ra(3'd6);
    wr(3'd6, 16'hBEEF, 2'b10);
    check_val("byp_a0", {16'h0, if_a.read_data[15:0]}, 32'hBEFF);
    check_val("byp_a1", {16'h0, if_a.read_data[31:16]}, 32'hBEFF);
    check_val("nobyp_b0", {16'h0, if_b.read_data[15:0]}, 32'h00FF);
    check_val("nobyp_b1", {16'h0, if_b.read_data[31:16]}, 32'h00FF);
    cycle();
    check_val("after_b0", {16'h0, if_b.read_data[15:0]}, 32'hBEFF);

    // Combinational read follows the address without a clock edge.
    wr(3'd7, 16'h0F0F, 2'b11);
    set_ra(3'd7);
    #1 check_val("lat0_a7", {16'h0, if_c.read_data[15:0]}, 32'h0F0F);
    ra[0] = 3'd1;
    #1 check_val("lat0_a1", {16'h0, if_c.read_data[15:0]}, {16'h0, m[1]});
    cycle();

    // Reset partway through the sweep restarts it from entry 0.
    reset = 1'b1; cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    bc = int'(if_a.busy);
    for (int i = 0; i < 10; i++) begin
      cycle();
      bc += int'(if_a.busy);
    end
    check_val("busy_len2", bc, 8);
    for (int a = 0; a < 8; a++) begin
      set_ra(3'(a));
      cycle();
      check_val("reswept", {16'h0, if_b.read_data[15:0]}, 32'h0);
    end

    // Four ports, repeated and wrapped addresses.
    for (int a = 0; a < 8; a++) wr(3'(a), 16'h1000 + 16'(a), 2'b11);
    ra[0] = 3'd7; ra[1] = 3'd0; ra[2] = 3'd7; ra[3] = 3'd3;
    #1;
    check_val("c4_p0", {16'h0, if_c.read_data[15:0]},  32'h1007);
    check_val("c4_p1", {16'h0, if_c.read_data[31:16]}, 32'h1000);
    check_val("c4_p2", {16'h0, if_c.read_data[47:32]}, 32'h1007);
    check_val("c4_p3", {16'h0, if_c.read_data[63:48]}, 32'h1003);
    cycle();
    check_val("b4_p0", {16'h0, if_b.read_data[15:0]},  32'h1007);
    check_val("b4_p1", {16'h0, if_b.read_data[31:16]}, 32'h1000);
    check_val("b4_p2", {16'h0, if_b.read_data[47:32]}, 32'h1007);
    check_val("b4_p3", {16'h0, if_b.read_data[63:48]}, 32'h1003);

    // Random traffic with occasional resets and frequent read-of-write-address collisions.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      w_en  = 1'($urandom_range(0, 1));
      wa    = 3'($urandom_range(0, 7));
      wd    = 16'($urandom);
      be    = 2'($urandom_range(0, 3));
      for (int p = 0; p < 4; p++) ra[p] = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port register file with per-byte write enables, selectable read latency and optional write-to-read bypass. It generalises the single-port storage of the circular FIFO and is the storage element for the next-generation multi-consumer FIFOs and small scratchpads. After reset, an internal sweep FSM clears every entry one per cycle, so no simulation or synthesis initial values are needed. The block reports when it is ready with `busy`.

Parameters:
- address_width, 3, entry index width; DEPTH = 2**address_width
- data_width, 16, entry width in bits; must be a multiple of 8; LANES = data_width/8
- num_read, 2, number of independent read ports (1..4)
- read_latency, 1, 0 = combinational read, 1 = registered read
- bypass, 1, 1 = a same-cycle write to the addressed entry is forwarded to the read data; 0 = old data is returned

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- w_en  in  1  write request
- write_address  in  address_width  write entry index
- write_data  in  data_width  write data
- byte_en  in  LANES  lane i covers write_data[8i+7:8i]; a lane is written only if its bit is 1
- read_address  in  num_read*address_width  port p address at [p*address_width +: address_width]
- read_data  out  num_read*data_width  port p data at [p*data_width +: data_width]
- busy  out  1  high while the clear sweep runs
- wr_drop  out  1  registered one-cycle pulse: a write was rejected

Behaviour:
- FSM states: INIT, READY.
- reset=1 at an edge:
  - state <= INIT, sweep counter <= 0, busy <= 1, wr_drop <= 0.
  - Registered read_data <= 0 (read_latency=1).
  - Memory contents are not touched on this edge.
- INIT:
  - Each edge writes 0 to mem[cnt] and increments cnt.
  - The edge that clears entry DEPTH-1 moves the FSM to READY and sets busy <= 0.
  - busy is therefore high for exactly DEPTH cycles after reset deasserts.
- Reset asserted mid-sweep restarts the sweep at entry 0. Partial clears are harmless.
- Writes during INIT (w_en=1, busy=1):
  - Ignored; memory is unchanged by the request.
  - wr_drop = 1 on the following cycle.
- READY:
  - On an edge with w_en=1, each lane with byte_en[i]=1 is updated. Other lanes keep their old value.
  - w_en=1 with byte_en=0 is a legal no-op; wr_drop stays 0.
- Reads during INIT: all read_data ports return 0, regardless of memory contents.
- read_latency=0:
  - read_data[p] = mem[read_address[p]] combinationally.
  - With bypass=1 and w_en & READY & (read_address[p]==write_address), enabled lanes show write_data and other lanes show stored data.
- read_latency=1:
  - read_data[p] is registered from the same expression as latency 0, sampled at the edge. Data appears one cycle after the address.
  - With bypass=1 this returns the merged new value. With bypass=0 it returns pre-write data.
- Independence rules:
  - Read ports are fully independent.
  - Any number of ports may read the same address, including the write address.
  - Each port obeys the bypass rule individually.
- Boundaries:
  - write_address and read_address wrap naturally; every value 0..DEPTH-1 is valid.
  - No out-of-range addresses are possible.
- Width rule: data_width not a multiple of 8, or num_read outside 1..4, is an elaboration error (fatal assertion).

Test Plan:
1. Reset sweep: assert reset 2 cycles, release, hold w_en=1 addr=5 data=16'hFFFF byte_en=2'b11.
   - busy high exactly 8 cycles after release.
   - wr_drop pulses each cycle one cycle after each rejected write.
   - Then read all 8 entries on both ports: every entry reads 16'h0000.
2. Byte enables (READY): write addr 3 = 16'hA55A with byte_en=2'b11, then addr 3 = 16'h1234 with byte_en=2'b01.
   - Port 0 reads addr 3 = 16'hA534.
   - Port 1 reads addr 2 = 16'h0000.
3. Same-cycle bypass (bypass=1, read_latency=1): mem[6]=16'h00FF; in one cycle write addr 6 = 16'hBEEF byte_en=2'b10 while both ports read addr 6.
   - Next cycle both ports = 16'hBEFF.
   - Repeat with bypass=0: both ports = 16'h00FF, and the following read = 16'hBEFF.
4. Latency 0: read_latency=0, read addr 7 after writing 16'h0F0F.
   - read_data valid in the same cycle the address is applied.
   - Changing the address to 1 changes the output with no clock edge.
5. Reset mid-sweep: release reset, re-assert at cycle 4 for 1 cycle, release.
   - busy stays high a further full 8 cycles.
   - All entries read 0 afterwards, including entries written before the first reset.
6. Wrap/all-ports: num_read=4; write addr 0..7 with 16'h1000+addr.
   - Ports read addresses {7,0,7,3} simultaneously.
   - Results: 16'h1007, 16'h1000, 16'h1007, 16'h1003.
